// File: rtl/alu_core_if.sv
// Operand/result bundle between the decode stage and the ALU execute unit.
// The master side supplies the operation and operands and observes the result;
// the slave side (the ALU) consumes the operation and drives the result.
interface alu_core_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       opsel;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] out;

    modport master (
        output opsel,
        output A,
        output B,
        input  out
    );

    modport slave (
        input  opsel,
        input  A,
        input  B,
        output out
    );
endinterface

// File: rtl/alu_core.sv
// Registered 32-bit execute-unit ALU: add, subtract, six bitwise logic ops and
// MVHI (load upper half). The result appears one clock after the operands and
// holds between updates. WIDTH must be even because MVHI splits the word into
// two equal halves. Unused opsel codes clear the result.
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    alu_core_if.slave  bus
);
    localparam int HALF = WIDTH / 2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_XNOR = 4'd7;
    localparam logic [3:0] OP_MVHI = 4'd8;

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    // Next result: pick the selected operation; MVHI keeps the current low half.
    always_comb begin
        out_d = '0;
        case (bus.opsel)
            OP_ADD:  out_d = bus.A + bus.B;
            OP_SUB:  out_d = bus.A - bus.B;
            OP_AND:  out_d = bus.A & bus.B;
            OP_OR:   out_d = bus.A | bus.B;
            OP_XOR:  out_d = bus.A ^ bus.B;
            OP_NAND: out_d = ~(bus.A & bus.B);
            OP_NOR:  out_d = ~(bus.A | bus.B);
            OP_XNOR: out_d = ~(bus.A ^ bus.B);
            OP_MVHI: out_d = {bus.B[HALF-1:0], out_q[HALF-1:0]};
            default: out_d = '0;
        endcase
    end

    // Result register with synchronous active-low clear that wins over any op.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.out = out_q;
endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core. Each driven operation pushes its expected
// result into a scoreboard queue; the entry is popped and compared just after
// the clock edge that should produce it.
module tb_alu_core;
    localparam int WIDTH = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_XNOR = 4'd7;
    localparam logic [3:0] OP_MVHI = 4'd8;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] value;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] model_out;
    int               total = 0;
    int               bad   = 0;

    alu_core_if #(.WIDTH(WIDTH)) bus ();

    alu_core #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Reference model of one clock's worth of ALU behaviour.
    function automatic logic [WIDTH-1:0] alu_model(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [WIDTH-1:0] cur);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NAND: return ~(a & b);
            OP_NOR:  return ~(a | b);
            OP_XNOR: return ~(a ^ b);
            OP_MVHI: return {b[WIDTH/2-1:0], cur[WIDTH/2-1:0]};
            default: return '0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Wait for the producing edge, then pop the oldest expectation and compare.
    task automatic popCompare();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            checkOutput(e.tag, bus.out, e.value);
        end
    endtask

    // Drive one operation on the falling edge and queue its expected result.
    // With use_model set, the expectation comes from the reference model;
    // otherwise the caller supplies a hand-derived constant.
    task automatic applyStimulus(input string tag, input logic rst_n,
                                 input logic [3:0] op,
                                 input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] expected,
                                 input bit use_model);
        exp_t e;
        @(negedge clk);
        reset_n   = rst_n;
        bus.opsel = op;
        bus.A     = a;
        bus.B     = b;
        e.tag     = tag;
        if (use_model) e.value = rst_n ? alu_model(op, a, b, model_out) : '0;
        else           e.value = expected;
        model_out = e.value;
        exp_q.push_back(e);
        popCompare();
    endtask

    initial begin
        exp_t e;
        reset_n   = 1'b0;
        bus.opsel = OP_ADD;
        bus.A     = 32'd20;
        bus.B     = 32'd17;
        model_out = '0;

        // Reset holds out at zero despite a live ADD; release gives the sum.
        applyStimulus("rst_cycle0", 1'b0, OP_ADD, 32'd20, 32'd17, 32'd0, 1'b0);
        applyStimulus("rst_cycle1", 1'b0, OP_ADD, 32'd20, 32'd17, 32'd0, 1'b0);
        applyStimulus("rst_release_add", 1'b1, OP_ADD, 32'd20, 32'd17, 32'd37, 1'b0);

        // Arithmetic including wraparound.
        applyStimulus("sub", 1'b1, OP_SUB, 32'd20, 32'd17, 32'd3, 1'b0);
        applyStimulus("add_wrap", 1'b1, OP_ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
        applyStimulus("sub_wrap", 1'b1, OP_SUB, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0);

        // Bitwise logic on 20 and 17.
        applyStimulus("and",  1'b1, OP_AND,  32'd20, 32'd17, 32'd16, 1'b0);
        applyStimulus("or",   1'b1, OP_OR,   32'd20, 32'd17, 32'd21, 1'b0);
        applyStimulus("xor",  1'b1, OP_XOR,  32'd20, 32'd17, 32'd5, 1'b0);
        applyStimulus("nand", 1'b1, OP_NAND, 32'd20, 32'd17, 32'hFFFFFFEF, 1'b0);
        applyStimulus("nor",  1'b1, OP_NOR,  32'd20, 32'd17, 32'hFFFFFFEA, 1'b0);
        applyStimulus("xnor", 1'b1, OP_XNOR, 32'd20, 32'd17, 32'hFFFFFFFA, 1'b0);

        // Back-to-back MVHI keeps the low half left by XNOR; A is ignored.
        applyStimulus("mvhi_1", 1'b1, OP_MVHI, 32'hDEADBEEF, 32'd17, 32'h0011FFFA, 1'b0);
        applyStimulus("mvhi_2", 1'b1, OP_MVHI, 32'h12345678, 32'h0000ABCD, 32'hABCDFFFA, 1'b0);

        // Reset mid-sequence clears out; the following MVHI preserves a zero low half.
        applyStimulus("rst_mid", 1'b0, OP_MVHI, 32'd1, 32'h00005555, 32'd0, 1'b0);
        applyStimulus("mvhi_after_rst", 1'b1, OP_MVHI, 32'd7, 32'hFFFF1234, 32'h12340000, 1'b0);

        // Every reserved code clears a nonzero result.
        for (int op = 9; op <= 15; op++) begin
            applyStimulus("pre_reserved_add", 1'b1, OP_ADD, 32'd20, 32'd17, 32'd37, 1'b0);
            applyStimulus($sformatf("reserved_%0d", op), 1'b1, 4'(op),
                          $urandom, $urandom, 32'd0, 1'b0);
        end

        // Inputs wiggling between edges must not disturb the registered result.
        applyStimulus("hold_setup", 1'b1, OP_XOR, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #2;
            bus.opsel = 4'(i * 4 + 1);
            bus.A     = $urandom;
            bus.B     = $urandom;
            checkOutput($sformatf("hold_%0d", i), bus.out, 32'hAAAAAAAA);
        end
        bus.opsel = OP_ADD;
        bus.A     = 32'd1000;
        bus.B     = 32'd234;
        e.tag     = "after_hold_add";
        e.value   = 32'd1234;
        model_out = e.value;
        exp_q.push_back(e);
        popCompare();

        // Random operations, including reserved codes and MVHI chains.
        for (int i = 0; i < 40; i++) begin
            applyStimulus($sformatf("rand_%0d", i), 1'b1, 4'($urandom_range(0, 15)),
                          $urandom, $urandom, 32'd0, 1'b1);
        end

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
